// File: rtl/fetch_unit_pkg.sv
// Shared fetch types and constants.
// Used by fetch_fifo and fetch_unit.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched instructions with their PCs.
// Same-cycle push and pop supported; clear empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        din,
    output entry_t        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, in-order imem requests, redirect drop.
// Optional perf counters enabled with FETCH_PERF_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        ifid_wren,
    input  logic        ifid_flush,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] f_pc,
    output logic [31:0] f_insn,
    output logic        f_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [CW-1:0] occ;
    logic [CW:0]   inflight;
    logic          accept;
    logic          rsp_drop;
    logic          rsp_live;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

    // Dropped requests are still physically in flight, so they hold slots.
    assign inflight = {1'b0, live} + {1'b0, drop} + {1'b0, occ};

    assign imem_req_valid = !reset && !stall_if && !ifid_flush
                         && (inflight < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_live = imem_rsp_valid && (drop == '0) && (live != '0);
    assign push     = rsp_live && !ifid_flush && (!full || pop);
    assign pop      = f_valid && ifid_wren && !ifid_flush;

    assign new_entry = '{pc: rsp_pc, insn: imem_rsp_data};

    assign f_valid = !empty;
    assign f_pc    = f_valid ? head.pc : rsp_pc;
    assign f_insn  = f_valid ? head.insn : NOP_INSN;

    // rsp_pc tags the next kept response; requests after a redirect are sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            live   <= '0;
            drop   <= '0;
        end else if (ifid_flush) begin
            pc     <= br_target;
            rsp_pc <= br_target;
            live   <= '0;
            drop   <= drop - CW'(rsp_drop) + live
                    - CW'(rsp_live) + CW'(accept);
        end else begin
            if (accept)
                pc <= pc + 32'd4;
            if (rsp_live)
                rsp_pc <= rsp_pc + 32'd4;
            live <= live + CW'(accept) - CW'(rsp_live);
            drop <= drop - CW'(rsp_drop);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .clear (ifid_flush),
        .din   (new_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall_if)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (ifid_flush)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency and control.
// Define FETCH_PERF_EN to also exercise the perf counters.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_if;
    logic        ifid_wren;
    logic        ifid_flush;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] f_pc;
    logic [31:0] f_insn;
    logic        f_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  acc_log[$];
    logic [31:0]  model_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .ifid_wren      (ifid_wren),
        .ifid_flush     (ifid_flush),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f_pc           (f_pc),
        .f_insn         (f_insn),
        .f_valid        (f_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Memory: in-order responses, random latency of at least one cycle.
    always begin
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = insn_of(mq[0].addr);
            void'(mq.pop_front());
        end
        #2;
        if (reset)
            mq.delete();
        else if (imem_req_valid && imem_req_ready)
            mq.push_back('{imem_req_addr,
                           cyc + int'($urandom_range(lat_max, lat_min))});
    end

    // Request side: predict the fetch address stream, queue expected heads.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            exp_q.delete();
            acc_log.delete();
            model_pc = RPC;
        end else if (ifid_flush) begin
            chk("no_req_on_flush", 32'(imem_req_valid), 32'd0);
            exp_q.delete();
            model_pc = br_target;
        end else begin
            if (stall_if)
                chk("no_req_on_stall", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                exp_q.push_back('{pc: model_pc, insn: insn_of(model_pc)});
                acc_log.push_back(imem_req_addr);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // Monitor: every instruction handed downstream must match the queue.
    always begin : mon
        fetch_entry_t e;
        @(negedge clk);
        #2;
        if (!reset) begin
            if (!f_valid)
                chk("nop_when_invalid", f_insn, NOP_INSN);
            else if (ifid_wren && !ifid_flush) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h, expected none",
                             f_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", f_pc, e.pc);
                    chk("head_insn", f_insn, e.insn);
                end
            end
        end
    end

    task automatic drive(input logic s, input logic w, input logic f,
                         input logic [31:0] bt, input logic rdy);
        @(negedge clk);
        stall_if       = s;
        ifid_wren      = w;
        ifid_flush     = f;
        br_target      = bt;
        imem_req_ready = rdy;
        #3;
    endtask

    task automatic do_reset(input logic w);
        @(negedge clk);
        reset          = 1'b1;
        stall_if       = 1'b0;
        ifid_wren      = w;
        ifid_flush     = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #3;
    endtask

    initial begin
        bit found;
        reset          = 1'b1;
        stall_if       = 1'b0;
        ifid_wren      = 1'b0;
        ifid_flush     = 1'b0;
        br_target      = '0;
        imem_req_ready = 1'b1;

        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        chk("rst_f_insn", f_insn, NOP_INSN);
        chk("rst_f_pc", f_pc, RPC);

        // Sequential fetch from reset with 1-cycle memory.
        @(negedge clk);
        reset     = 1'b0;
        ifid_wren = 1'b1;
        #3;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RPC);
        repeat (8) drive(0, 1, 0, '0, 1);
        chk("seq_accepts", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3)
            for (int i = 0; i < 3; i++)
                chk("seq_addr", acc_log[i], RPC + 32'(4 * i));

        // Stall with a full FIFO holds the head and issues nothing.
        do_reset(1'b0);
        repeat (4) drive(0, 0, 0, '0, 1);
        repeat (3) begin
            drive(1, 0, 0, '0, 1);
            chk("stall_head_valid", 32'(f_valid), 32'd1);
            chk("stall_head_pc", f_pc, RPC);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        repeat (6) drive(0, 1, 0, '0, 1);

        // Redirect with two requests in flight: both responses dropped.
        lat_min = 3;
        lat_max = 3;
        do_reset(1'b1);
        drive(0, 1, 0, '0, 1);
        drive(0, 1, 1, 32'h0100_0040, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive(0, 1, 0, '0, 1);
            if (f_valid) begin
                found = 1'b1;
                chk("redirect_pc", f_pc, 32'h0100_0040);
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL redirect_timeout: got no valid head, expected pc %h",
                     32'h0100_0040);
        end

        // Flush together with stall still redirects.
        lat_min = 1;
        lat_max = 2;
        repeat (4) drive(0, 1, 0, '0, 1);
        drive(1, 1, 1, 32'h0200_0000, 1);
        drive(1, 1, 0, '0, 1);
        chk("flush_stall_pc", imem_req_addr, 32'h0200_0000);
        chk("flush_stall_no_req", 32'(imem_req_valid), 32'd0);

        // Memory not ready: address must not move.
        repeat (4) begin
            drive(0, 1, 0, '0, 0);
            chk("noready_addr", imem_req_addr, 32'h0200_0000);
        end
        repeat (6) drive(0, 1, 0, '0, 1);

        // PC wrap across 2^32.
        drive(0, 1, 1, 32'hFFFF_FFF8, 1);
        repeat (12) drive(0, 1, 0, '0, 1);
        chk("wrap_pc_reached", 32'(model_pc < 32'h0000_0100), 32'd1);

        // Random traffic with occasional mid-flight resets.
        lat_min = 1;
        lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350)
                do_reset(1'($urandom % 2));
            else
                drive(($urandom % 5) == 0, ($urandom % 4) != 0,
                      ($urandom % 19) == 0,
                      (($urandom % 4) == 0) ? 32'hFFFF_FFF8
                                            : ($urandom & 32'hFFFF_FFFC),
                      ($urandom % 3) != 0);
        end

`ifdef FETCH_PERF_EN
        do_reset(1'b0);
        repeat (5) drive(1, 0, 0, '0, 1);
        repeat (2) drive(0, 0, 1, 32'h0100_0080, 1);
        drive(0, 0, 0, '0, 1);
        chk("perf_stall", perf_stall_cycles, 32'd5);
        chk("perf_flush", perf_flush_count, 32'd2);
`endif

        repeat (4) drive(0, 0, 0, '0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0100_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the maximum number of in-flight requests plus buffered instructions.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall_if  input  1  hold PC; issue no new request.
REQ-006 ifid_wren  input  1  downstream accepts the head instruction this cycle.
REQ-007 ifid_flush  input  1  redirect: branch taken in EX.
REQ-008 br_target  input  32  redirect PC, sampled when ifid_flush=1.
REQ-009 imem_req_valid  output  1  fetch request valid.
REQ-010 imem_req_ready  input  1  memory accepts the request.
REQ-011 imem_req_addr  output  32  fetch address.
REQ-012 imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-013 imem_rsp_data  input  32  response instruction word.
REQ-014 f_pc  output  32  PC of the head instruction.
REQ-015 f_insn  output  32  head instruction; 32'h0000_0013 (NOP) when f_valid=0.
REQ-016 f_valid  output  1  head instruction valid.

Function
REQ-017 A request is issued when imem_req_valid && imem_req_ready; then PC <= PC+4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
REQ-018 imem_req_valid = !stall_if && !ifid_flush && (outstanding + occupancy < DEPTH); imem_req_addr = PC.
REQ-019 Each kept response is written to a DEPTH-entry FIFO tagged with its request PC; f_pc/f_insn/f_valid come from the FIFO head, combinationally.
REQ-020 Pop the head when f_valid && ifid_wren && !ifid_flush; the FIFO supports push and pop in the same cycle.
REQ-021 Response arriving with the FIFO empty: f_valid rises the following cycle (registered FIFO, no bypass).
REQ-022 On ifid_flush: PC <= br_target; FIFO cleared; drop_cnt <= outstanding count, including any request accepted that same cycle.
REQ-023 While drop_cnt > 0, each imem_rsp_valid decrements drop_cnt and the response is discarded, never written to the FIFO.
REQ-024 Flush has priority over stall, pop, issue and push in the same cycle.
REQ-025 Flush while drop_cnt > 0: drop_cnt = previous drop_cnt + outstanding non-dropped requests.
REQ-026 stall_if=1 with ifid_wren=0: PC, FIFO and outputs hold; in-flight responses still push.
REQ-027 imem_rsp_valid with no outstanding request is ignored.
REQ-028 Counters are sized $clog2(DEPTH+1) bits and never wrap.

Reset
REQ-029 While reset=1: PC=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
REQ-030 Outputs during reset: imem_req_valid=0, f_valid=0, f_insn=NOP, f_pc=RESET_PC.
REQ-031 Reset asserted mid-transaction abandons all in-flight responses.
REQ-032 The first request issues in the first cycle after reset deasserts.

Configuration
REQ-033 With FETCH_PERF_EN defined, add outputs perf_stall_cycles (32) and perf_flush_count (32).
REQ-034 perf_stall_cycles increments each cycle stall_if=1; perf_flush_count increments each cycle ifid_flush=1.
REQ-035 Both perf counters reset to 0 and wrap modulo 2^32.
REQ-036 Without FETCH_PERF_EN, the perf ports and their logic are absent and behaviour is otherwise identical.

Structure
REQ-037 Shared package holds NOP_INSN=32'h0000_0013, RESET_PC_DEFAULT and typedef fetch_entry_t {pc[31:0], insn[31:0]}.
REQ-038 The FIFO is sub-module fetch_fifo, parameterized on DEPTH and the entry type, with push, pop, clear, full and empty.

Verification
REQ-039 Reset release, ready=1, 1-cycle responses -> addresses 0x0100_0000, 0x0100_0004, 0x0100_0008 in consecutive cycles; f_pc follows in order.
REQ-040 stall_if=1 and ifid_wren=0 for 3 cycles, head at 0x0100_0008 -> f_pc holds 0x0100_0008; no request issued; FIFO never exceeds 2.
REQ-041 ifid_flush with br_target=0x0100_0040 and 2 outstanding -> both stale responses dropped; next f_pc=0x0100_0040; f_valid=0 until it arrives.
REQ-042 Flush and stall in the same cycle -> redirect occurs; PC=br_target next cycle.
REQ-043 imem_req_ready=0 for 4 cycles -> imem_req_addr stable and PC unchanged.
REQ-044 FETCH_PERF_EN build, 5 stall cycles and 2 flushes -> perf_stall_cycles=5, perf_flush_count=2.
